mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
// Iterative HI/LO multiply/divide unit for the MIPS datapath. Sits directly downstream of the
// register file: consumes the RD1/RD2 operand pair (rs/rt) and executes MULT, MULTU, DIV and DIVU
// over 32 cycles. Executes MTHI/MTLO in a single cycle. Holds the architectural HI/LO registers
// that MFHI/MFLO read back. A start/busy/done handshake lets the control unit stall on it.
// PARAMETERS
// WIDTH   32   operand and HI/LO width; iteration count equals WIDTH
// CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk      in   1      rising-edge clock
// rst_n    in   1      asynchronous active-low reset
// start    in   1      request; sampled only when busy==0
// op       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op)
// rs_val   in   WIDTH  rs operand (regfile RD1): multiplicand / dividend / MTHI/MTLO data
// rt_val   in   WIDTH  rt operand (regfile RD2): multiplier / divisor
// busy     out  1      iterative operation in progress
// done     out  1      one-cycle pulse: HI/LO were updated at the preceding edge
// hi       out  WIDTH  HI register (MFHI source)
// lo       out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
// - Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, FSM to IDLE, counter=0. No wait for clk.
//   Reset mid-operation aborts the operation; no result is written and no done pulse is produced.
// - FSM states: IDLE, MUL, DIV.
//   - IDLE -> MUL on start & op in {MULT,MULTU}.
//   - IDLE -> DIV on start & op in {DIV,DIVU}.
//   - MUL/DIV -> IDLE when the counter reaches WIDTH-1.
// - Accept at edge E0 (start=1, busy=0): operands are latched; rs_val/rt_val are don't-care afterwards.
//   busy=1 from after E0 until E32. The result is written to hi/lo at E32, when busy falls.
//   done=1 for exactly the cycle after E32. Latency is 32 cycles from accept to visible result.
// - hi/lo hold their previous values while busy, with no partial results exposed.
// - start while busy=1 is ignored entirely; this includes MTHI/MTLO.
// - MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the accepting edge. done pulses the next cycle.
//   busy stays 0. The other register is unchanged.
// - Reserved op with start: no state change and no done pulse.
// - Multiply: unsigned shift-add over magnitudes, producing a 64-bit product {hi,lo}.
//   - MULT (signed): take the 2's-complement magnitude of each operand. Negate the 64-bit product
//     if the sign bits differ.
//   - MULTU: operands are unsigned.
// - Divide: restoring, one quotient bit per cycle, over magnitudes.
//   - lo = quotient, hi = remainder.
//   - DIV (signed): quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
//     Truncation is toward zero.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is a wrap with no trap.
//   - Divisor == 0 (DIV or DIVU): lo=0xFFFFFFFF, hi=rs_val as latched. Full 32-cycle latency still
//     applies.
// - Sign correction happens combinationally on the final write. It adds no cycle.
// - done and a new accept can coincide: a start in the done cycle is accepted, because busy=0.
// TESTING
// 1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles; hi=0xFFFFFFFE, lo=0x00000001; done for 1 cycle.
// 2. MULT 0xFFFFFFFD(-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
//    MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
// 3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
// 4. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 after 32 cycles.
//    MTLO 0xCAFE in IDLE -> lo=0xCAFE next edge; done pulses; busy never rises.
// 5. Start DIVU, then pulse start with MTHI 0xDEAD at cycle 5 -> ignored; final hi is the remainder.
//    Back-to-back MULTU issued in the done cycle -> accepted.
// 6. Assert rst_n=0 mid-edge at cycle 10 of a DIV -> busy/done/hi/lo go to 0 immediately.
//    No done follows. The next DIV completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the HI/LO multiply/divide unit.
// The control unit is the master; the arithmetic unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide over
// operand magnitudes, one bit per cycle, with sign fix-up folded into the final write.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic is_signed);
    if (is_signed && v[WIDTH-1]) return ~v + WIDTH'(1);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                      input logic neg);
    return neg ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  // Control state (reset)
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Working datapath (not reset; only meaningful while busy)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rs_lat_q, rs_lat_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;

  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic                    op_signed;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_b;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign rs_s      = bus.rs_val;
  assign rt_s      = bus.rt_val;
  assign op_signed = ~bus.op[0];

  // One iteration step of each algorithm, evaluated every cycle
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_acc   = mul_sum[WIDTH:1];
    mul_b     = {mul_sum[0], b_q[WIDTH-1:1]};

    div_shift = {acc_q, b_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, a_q};
    div_diff  = div_shift[WIDTH-1:0] - a_q;
    div_acc   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_b     = {b_q[WIDTH-2:0], div_ge};

    prod_fix  = cond_neg_2w({mul_acc, mul_b}, neg_q);
    quot_fix  = cond_neg_w(div_b, neg_q);
    rem_fix   = cond_neg_w(div_acc, rneg_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rs_lat_d = rs_lat_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          if (bus.op[2:1] == 2'b00) begin
            state_d = S_MUL;
            a_d     = magnitude(rs_s, op_signed);
            b_d     = magnitude(rt_s, op_signed);
            acc_d   = '0;
            neg_d   = op_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
          end else if (bus.op[2:1] == 2'b01) begin
            state_d  = S_DIV;
            a_d      = magnitude(rt_s, op_signed);
            b_d      = magnitude(rs_s, op_signed);
            acc_d    = '0;
            rs_lat_d = bus.rs_val;
            neg_d    = op_signed & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            rneg_d   = op_signed & bus.rs_val[WIDTH-1];
            divz_d   = (bus.rt_val == '0);
          end else if (bus.op == OP_MTHI) begin
            hi_d   = bus.rs_val;
            done_d = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            lo_d   = bus.rs_val;
            done_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        acc_d = mul_acc;
        b_d   = mul_b;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = prod_fix;
          done_d       = 1'b1;
        end
      end

      S_DIV: begin
        acc_d = div_acc;
        b_d   = div_b;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          // A zero divisor reports all-ones quotient and the untouched dividend
          if (divz_q) begin
            lo_d = '1;
            hi_d = rs_lat_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    acc_q    <= acc_d;
    rs_lat_q <= rs_lat_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    divz_q   <= divz_d;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
